// File: rtl/apb_periph_hub.sv
// APB fabric stage: decodes one upstream transfer to a downstream slot, wakes gated slaves
// on demand and registers the response. Watchdog is present only with APB_HUB_TIMEOUT_EN.
module apb_periph_hub #(
  parameter int NUM_SLAVES     = 8,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int SLOT_LSB       = 12,
  parameter int WAKE_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [APB_ADDR_WIDTH-1:0]  paddr_i,
  input  logic                       psel_i,
  input  logic                       penable_i,
  input  logic                       pwrite_i,
  input  logic [31:0]                pwdata_i,
  output logic [31:0]                prdata_o,
  output logic                       pready_o,
  output logic                       pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]  m_paddr_o,
  output logic                       m_pwrite_o,
  output logic [31:0]                m_pwdata_o,
  output logic                       m_penable_o,
  output logic [NUM_SLAVES-1:0]      m_psel_o,
  input  logic [NUM_SLAVES*32-1:0]   m_prdata_i,
  input  logic [NUM_SLAVES-1:0]      m_pready_i,
  input  logic [NUM_SLAVES-1:0]      m_pslverr_i,
  input  logic [NUM_SLAVES-1:0]      gate_ctrl_i,
  input  logic                       auto_wake_i,
  output logic [NUM_SLAVES-1:0]      clk_en_o,
  output logic                       timeout_o,
  output logic [4:0]                 timeout_slot_o,
  input  logic                       timeout_clr_i
);

  // Slot field is decoded at the full 5-bit width so aliased high slots are rejected.
  localparam int SLOT_W = 5;

  typedef enum logic [2:0] {S_IDLE, S_WAKE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      write_q, write_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [3:0]                wake_q, wake_d;
  logic [31:0]               prdata_q, prdata_d;
  logic                      pslverr_q, pslverr_d;

  logic [SLOT_W-1:0] in_slot;
  logic              in_valid, in_gated;
  logic [31:0]       sel_rdata;
  logic              sel_ready, sel_err;
  logic              wdog_expire;

  always_comb begin
    in_slot   = paddr_i[SLOT_LSB +: SLOT_W];
    in_valid  = int'(in_slot) < NUM_SLAVES;
    in_gated  = 1'b0;
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (in_slot == SLOT_W'(i)) in_gated = !gate_ctrl_i[i];
      if (slot_q == SLOT_W'(i)) begin
        sel_rdata = m_prdata_i[32*i +: 32];
        sel_ready = m_pready_i[i];
        sel_err   = m_pslverr_i[i];
      end
    end
  end

`ifdef APB_HUB_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
  logic [4:0]  tslot_q, tslot_d;

  assign wdog_expire = (state_q == S_ACCESS) && (wdog_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    tslot_d   = tslot_q;
    if (state_q == S_SETUP) wdog_d = '0;
    else if (state_q == S_ACCESS && !sel_ready) wdog_d = wdog_q + 16'd1;
    // A new expiry in the same cycle as a clear keeps the flag set.
    if (wdog_expire && !sel_ready) begin
      timeout_d = 1'b1;
      tslot_d   = slot_q;
    end else if (timeout_clr_i) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      tslot_q   <= '0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      tslot_q   <= tslot_d;
    end
  end

  assign timeout_o      = timeout_q;
  assign timeout_slot_o = tslot_q;
`else
  logic unused_clr;
  assign unused_clr     = timeout_clr_i;
  assign wdog_expire    = 1'b0;
  assign timeout_o      = 1'b0;
  assign timeout_slot_o = '0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    slot_d    = slot_q;
    wake_d    = wake_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    case (state_q)
      S_IDLE: begin
        if (psel_i && !penable_i) begin
          addr_d  = paddr_i;
          write_d = pwrite_i;
          wdata_d = pwdata_i;
          slot_d  = in_slot;
          if (!in_valid || (in_gated && !auto_wake_i)) begin
            state_d   = S_RESP;
            prdata_d  = '0;
            pslverr_d = 1'b1;
          end else if (in_gated) begin
            state_d = S_WAKE;
            wake_d  = 4'(WAKE_CYCLES);
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_WAKE: begin
        wake_d = wake_q - 4'd1;
        if (wake_q <= 4'd1) state_d = S_SETUP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (sel_ready) begin
          state_d   = S_RESP;
          prdata_d  = write_q ? 32'h0 : sel_rdata;
          pslverr_d = sel_err;
        end else if (wdog_expire) begin
          state_d   = S_RESP;
          prdata_d  = '0;
          pslverr_d = 1'b1;
        end
      end
      S_RESP: begin
        state_d   = S_IDLE;
        prdata_d  = '0;
        pslverr_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      slot_q    <= '0;
      wake_q    <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      slot_q    <= slot_d;
      wake_q    <= wake_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign pready_o    = (state_q == S_RESP);
  assign prdata_o    = prdata_q;
  assign pslverr_o   = pslverr_q;
  assign m_paddr_o   = addr_q;
  assign m_pwrite_o  = write_q;
  assign m_pwdata_o  = wdata_q;
  assign m_penable_o = (state_q == S_ACCESS);

  // The forced enable follows the captured slot, so a falling gate bit cannot cut an access short.
  always_comb begin
    m_psel_o = '0;
    clk_en_o = gate_ctrl_i;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        if (state_q == S_SETUP || state_q == S_ACCESS) m_psel_o[i] = 1'b1;
        if (state_q != S_IDLE) clk_en_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_periph_hub.sv
// Self-checking bench for apb_periph_hub: directed plan scenarios plus randomized transfers
// checked against a cycle-budget model of decode, wake, access and response timing.
module tb_apb_periph_hub;

  localparam int NS    = 8;
  localparam int AW    = 32;
  localparam int WAKE  = 2;
  localparam int TMO   = 255;
  localparam int NEVER = 1000000;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [AW-1:0]    paddr_i;
  logic             psel_i, penable_i, pwrite_i;
  logic [31:0]      pwdata_i;
  logic [31:0]      prdata_o;
  logic             pready_o, pslverr_o;
  logic [AW-1:0]    m_paddr_o;
  logic             m_pwrite_o, m_penable_o;
  logic [31:0]      m_pwdata_o;
  logic [NS-1:0]    m_psel_o;
  logic [NS*32-1:0] m_prdata_i;
  logic [NS-1:0]    m_pready_i, m_pslverr_i, gate_ctrl_i, clk_en_o;
  logic             auto_wake_i;
  logic             timeout_o;
  logic [4:0]       timeout_slot_o;
  logic             timeout_clr_i;

  apb_periph_hub #(
    .NUM_SLAVES(NS), .APB_ADDR_WIDTH(AW), .SLOT_LSB(12),
    .WAKE_CYCLES(WAKE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .paddr_i(paddr_i), .psel_i(psel_i),
    .penable_i(penable_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .m_paddr_o(m_paddr_o), .m_pwrite_o(m_pwrite_o), .m_pwdata_o(m_pwdata_o),
    .m_penable_o(m_penable_o), .m_psel_o(m_psel_o), .m_prdata_i(m_prdata_i),
    .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i), .gate_ctrl_i(gate_ctrl_i),
    .auto_wake_i(auto_wake_i), .clk_en_o(clk_en_o), .timeout_o(timeout_o),
    .timeout_slot_o(timeout_slot_o), .timeout_clr_i(timeout_clr_i)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("FAIL global_time_limit reached got=running exp=finished");
    $fatal(1, "time limit");
  end

  // Scoreboard: expected response {pslverr, prdata}
  logic [32:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        exp_to;
  logic [4:0]  exp_tslot;
  logic        churn;

  // Driver + reference model for one transfer. The model derives the whole timeline from the
  // decode rules: select window, enable window, forced clock window and response cycle.
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [7:0] gate, input logic aw, input int waits,
                          input logic [31:0] rdata, input logic serr, input int max_c);
    int          slot, sel_start, lat, acc_cnt;
    bit          valid, gated, early, tmo;
    logic [32:0] exp_rsp, got;
    logic [7:0]  force_mask, exp_sel;
    slot      = int'(addr[16:12]);
    valid     = slot < NS;
    gated     = valid && !gate[slot];
    early     = !valid || (gated && !aw);
    sel_start = gated ? 1 + WAKE : 1;
    tmo       = 1'b0;
    if (early) lat = 1;
`ifdef APB_HUB_TIMEOUT_EN
    else if (waits >= TMO) begin tmo = 1'b1; lat = sel_start + 1 + TMO; end
`endif
    else if (waits >= NEVER) lat = NEVER;
    else lat = sel_start + 2 + waits;
    exp_rsp    = (early || tmo) ? {1'b1, 32'h0} : {serr, (wr ? 32'h0 : rdata)};
    force_mask = valid ? 8'(1 << slot) : 8'h00;
    exp_q.push_back(exp_rsp);

    @(negedge clk_i);
    gate_ctrl_i = gate; auto_wake_i = aw;
    paddr_i = addr; pwrite_i = wr; pwdata_i = wdata; psel_i = 1'b1; penable_i = 1'b0;
    for (int i = 0; i < NS; i++) m_prdata_i[32*i +: 32] = $urandom;
    m_pslverr_i = 8'($urandom);
    m_pready_i  = 8'($urandom);
    if (valid) begin
      m_prdata_i[32*slot +: 32] = rdata;
      m_pslverr_i[slot] = serr;
      m_pready_i[slot]  = 1'b0;
    end
    acc_cnt = 0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk_i);
      penable_i = 1'b1;
      paddr_i   = $urandom;
      if (churn) gate_ctrl_i = 8'($urandom);
      m_pready_i = 8'($urandom);
      if (valid) begin
        if (m_psel_o[slot] && m_penable_o) acc_cnt++;
        m_pready_i[slot] = m_psel_o[slot] && m_penable_o && ((acc_cnt - 1) >= waits);
      end
      #1;
      exp_sel = (!early && c >= sel_start && c < lat) ? force_mask : 8'h00;
      checks++;
      if (m_psel_o !== exp_sel) begin
        errors++; $display("FAIL m_psel c=%0d got=%h exp=%h", c, m_psel_o, exp_sel);
      end
      checks++;
      if (m_penable_o !== (!early && c > sel_start && c < lat)) begin
        errors++; $display("FAIL m_penable c=%0d got=%b", c, m_penable_o);
      end
      checks++;
      if (clk_en_o !== (gate_ctrl_i | ((c <= lat) ? force_mask : 8'h00))) begin
        errors++; $display("FAIL clk_en c=%0d got=%h gate=%h force=%h", c, clk_en_o, gate_ctrl_i, force_mask);
      end
      checks++;
      if (pready_o !== (c == lat)) begin
        errors++; $display("FAIL pready c=%0d got=%b exp_cycle=%0d", c, pready_o, lat);
      end
      if (exp_sel != 8'h00) begin
        checks++;
        if (m_paddr_o !== addr || m_pwrite_o !== wr || m_pwdata_o !== wdata) begin
          errors++;
          $display("FAIL m_shared c=%0d got=%h/%b/%h exp=%h/%b/%h", c, m_paddr_o, m_pwrite_o,
                   m_pwdata_o, addr, wr, wdata);
        end
      end
      if (tmo && c == lat) begin exp_to = 1'b1; exp_tslot = 5'(slot); end
      checks++;
      if (timeout_o !== exp_to || timeout_slot_o !== exp_tslot) begin
        errors++; $display("FAIL timeout c=%0d got=%b/%0d exp=%b/%0d", c, timeout_o,
                           timeout_slot_o, exp_to, exp_tslot);
      end
      if (pready_o) begin
        got = {pslverr_o, prdata_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL response got=%h exp=none", got);
        end else begin
          exp_rsp = exp_q.pop_front();
          if (got !== exp_rsp) begin
            errors++; $display("FAIL response got=%h exp=%h", got, exp_rsp);
          end
        end
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      psel_i = 1'b0; penable_i = 1'b0; m_pready_i = '0;
      #1;
      checks++;
      if (pready_o !== 1'b0 || m_psel_o !== 8'h00 || m_penable_o !== 1'b0 ||
          clk_en_o !== gate_ctrl_i) begin
        errors++; $display("FAIL idle got=%b/%h/%b/%h gate=%h", pready_o, m_psel_o,
                           m_penable_o, clk_en_o, gate_ctrl_i);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (m_psel_o !== 8'h00 || m_penable_o !== 1'b0 || pready_o !== 1'b0 || prdata_o !== 32'h0 ||
        pslverr_o !== 1'b0 || timeout_o !== 1'b0 || m_paddr_o !== 32'h0 ||
        clk_en_o !== gate_ctrl_i) begin
      errors++;
      $display("FAIL %s got psel=%h en=%b rdy=%b rd=%h err=%b to=%b addr=%h clk_en=%h gate=%h", tag,
               m_psel_o, m_penable_o, pready_o, prdata_o, pslverr_o, timeout_o, m_paddr_o,
               clk_en_o, gate_ctrl_i);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    gate_ctrl_i = 8'hA5; #1;
    check_reset_outputs("reset_state_a5");
    gate_ctrl_i = 8'h3C; #1;
    check_reset_outputs("reset_state_3c");
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(2);
  endtask

  task automatic test_basic_read();
    run_xfer(32'h0000_3004, 1'b0, 32'h0, 8'hFF, 1'b1, 0, 32'hCAFE_F00D, 1'b0, 10);
    idle(1);
  endtask

  task automatic test_wake_write();
    run_xfer(32'h0000_5000, 1'b1, 32'h1234_5678, 8'h00, 1'b1, 0, 32'hDEAD_BEEF, 1'b0, 12);
    idle(1);
  endtask

  task automatic test_gated_error();
    run_xfer(32'h0000_5000, 1'b1, 32'h1234_5678, 8'h00, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 6);
    idle(1);
  endtask

  task automatic test_invalid_slot();
    run_xfer(32'h0000_9000, 1'b0, 32'h0, 8'h6B, 1'b1, 0, 32'h1111_2222, 1'b0, 6);
    idle(1);
  endtask

  task automatic do_reset(input logic [7:0] gate);
    #2;
    psel_i = 1'b0; penable_i = 1'b0; m_pready_i = '0; gate_ctrl_i = gate;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("reset_mid_access");
    exp_q.delete();
    exp_to = 1'b0; exp_tslot = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef APB_HUB_TIMEOUT_EN
    run_xfer(32'h0000_2000, 1'b0, 32'h0, 8'hFF, 1'b1, NEVER, 32'h0, 1'b0, TMO + 10);
    idle(1);
    checks++;
    if (timeout_o !== 1'b1 || timeout_slot_o !== 5'd2) begin
      errors++; $display("FAIL timeout_sticky got=%b/%0d exp=1/2", timeout_o, timeout_slot_o);
    end
    @(negedge clk_i); timeout_clr_i = 1'b1;
    @(negedge clk_i); timeout_clr_i = 1'b0; #1;
    exp_to = 1'b0;
    checks++;
    if (timeout_o !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got=%b exp=0", timeout_o);
    end
`else
    run_xfer(32'h0000_2000, 1'b0, 32'h0, 8'hFF, 1'b1, NEVER, 32'h0, 1'b0, 300);
    @(negedge clk_i); timeout_clr_i = 1'b1; #1;
    checks++;
    if (timeout_o !== 1'b0 || timeout_slot_o !== 5'd0 || m_psel_o !== 8'h04 || m_penable_o !== 1'b1) begin
      errors++; $display("FAIL no_watchdog_hold got=%b/%0d/%h/%b exp=0/0/04/1", timeout_o,
                         timeout_slot_o, m_psel_o, m_penable_o);
    end
    @(negedge clk_i); timeout_clr_i = 1'b0;
    do_reset(8'hFF);
`endif
    idle(1);
  endtask

  task automatic test_reset_mid_access();
    run_xfer(32'h0000_1000, 1'b0, 32'h0, 8'hFD, 1'b1, NEVER, 32'h0, 1'b0, 6);
    do_reset(8'h96);
    idle(1);
    run_xfer(32'h0000_1010, 1'b0, 32'h0, 8'hFF, 1'b1, 1, 32'h5A5A_0001, 1'b0, 12);
    idle(1);
  endtask

  task automatic test_back_to_back();
    run_xfer(32'h0000_0008, 1'b0, 32'h0, 8'hFF, 1'b1, 0, 32'hA000_0000, 1'b0, 10);
    run_xfer(32'h0000_7008, 1'b1, 32'hB1B2_B3B4, 8'hFF, 1'b1, 2, 32'h0, 1'b1, 10);
    run_xfer(32'h0000_4008, 1'b0, 32'h0, 8'hEF, 1'b1, 1, 32'hC0C0_C0C0, 1'b1, 12);
    run_xfer(32'h0001_F000, 1'b0, 32'h0, 8'hFF, 1'b1, 0, 32'h0, 1'b0, 6);
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      addr = $urandom;
      addr[16:12] = 5'($urandom_range(0, 9));
      churn = n[0];
      run_xfer(addr, 1'($urandom), $urandom, 8'($urandom), 1'($urandom),
               $urandom_range(0, 3), $urandom, 1'($urandom), 20);
      churn = 1'b0;
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

  initial begin
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0;
    pwdata_i = '0; m_prdata_i = '0; m_pready_i = '0; m_pslverr_i = '0;
    gate_ctrl_i = 8'hFF; auto_wake_i = 1'b1; timeout_clr_i = 1'b0;
    churn = 1'b0; exp_to = 1'b0; exp_tslot = '0;
    test_reset();
    test_basic_read();
    test_wake_write();
    test_gated_error();
    test_invalid_slot();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
